// File: rtl/pow5_credit_buffer.sv
// pow5_credit_buffer: credit-gated result FIFO behind the x^5 pipeline, presented as an AXI-Stream master.
// Define POW5_BUF_TLAST_EN to add m_axis_tlast_o with a PACKET_LEN-beat packet counter.
module pow5_credit_buffer #(
    parameter int DATA_WIDTH   = 40,
    parameter int DEPTH        = 8,
    parameter int PIPE_LATENCY = 5,
    parameter int PACKET_LEN   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [DATA_WIDTH-1:0]   pipe_data_i,
    input  logic                    pipe_valid_i,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic                    m_axis_tvalid_o,
    input  logic                    m_axis_tready_i,
`ifdef POW5_BUF_TLAST_EN
    output logic                    m_axis_tlast_o,
`endif
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic                    issue_err_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < PIPE_LATENCY + 1 || (DEPTH & (DEPTH - 1)) != 0 || PACKET_LEN < 1) begin : g_bad_params
        $error("pow5_credit_buffer: DEPTH must be a power of 2 >= PIPE_LATENCY+1 and PACKET_LEN >= 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           reserved;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  issue;

    // Occupancy falls out of the wrap-bit pointer difference; full when it reaches DEPTH
    assign count_o         = wr_ptr - rd_ptr;
    assign empty           = wr_ptr == rd_ptr;
    assign full            = count_o == (AW+1)'(DEPTH);
    assign m_axis_tvalid_o = !empty;
    assign m_axis_tdata_o  = mem[rd_ptr[AW-1:0]];
    assign pop             = m_axis_tvalid_o & m_axis_tready_i;
    assign push            = pipe_valid_i & (!full | pop);
    assign issue_ready_o   = reserved < (AW+1)'(DEPTH);
    assign issue           = issue_valid_i & issue_ready_o;

    // Pointers, credit count and sticky error flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            reserved    <= '0;
            overflow_o  <= 1'b0;
            issue_err_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (issue != pop) reserved <= issue ? reserved + 1'b1 : reserved - 1'b1;
            if (pipe_valid_i & !push) overflow_o <= 1'b1;
            if (issue_valid_i & !issue_ready_o) issue_err_o <= 1'b1;
        end
    end

    // Result storage; contents need no reset since empty masks them
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pipe_data_i;
    end

`ifdef POW5_BUF_TLAST_EN
    localparam int BW = $clog2(PACKET_LEN + 1);

    logic [BW-1:0] beat;

    assign m_axis_tlast_o = m_axis_tvalid_o & (beat == BW'(PACKET_LEN - 1));

    // Beat position within the current packet, advanced by each accepted beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) beat <= '0;
        else if (pop) beat <= (beat == BW'(PACKET_LEN - 1)) ? '0 : beat + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pow5_credit_buffer.sv
// tb_pow5_credit_buffer: randomized self-checking bench for pow5_credit_buffer against a queue-based model.
// Honours POW5_BUF_TLAST_EN to also check m_axis_tlast_o.
module tb_pow5_credit_buffer;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [39:0] pipe_data_i = '0;
    logic        pipe_valid_i = 1'b0;
    logic [39:0] m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i = 1'b0;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic        issue_err_o;
`ifdef POW5_BUF_TLAST_EN
    logic        m_axis_tlast_o;
`endif

    typedef struct {
        int          due;
        logic [39:0] d;
    } ev_t;

    logic [39:0] q[$];
    ev_t         sched[$];
    int          reserved_m = 0;
    bit          ovf_m = 0;
    bit          err_m = 0;
    int          beats_m = 0;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;

    pow5_credit_buffer dut (
        .clk_i(clk),
        .rst_n_i(rst_n_i),
        .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o),
        .pipe_data_i(pipe_data_i),
        .pipe_valid_i(pipe_valid_i),
        .m_axis_tdata_o(m_axis_tdata_o),
        .m_axis_tvalid_o(m_axis_tvalid_o),
        .m_axis_tready_i(m_axis_tready_i),
`ifdef POW5_BUF_TLAST_EN
        .m_axis_tlast_o(m_axis_tlast_o),
`endif
        .count_o(count_o),
        .overflow_o(overflow_o),
        .issue_err_o(issue_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pow5(input logic [7:0] x);
        logic [39:0] v;
        v = {32'd0, x};
        return v * v * v * v * v;
    endfunction

    // One clock cycle: compare outputs with the model, drive inputs, advance the model and the clock.
    // The bench plays the x^5 pipeline: an accepted issue returns its result 5 cycles later.
    task automatic step(input bit iv, input bit tr, input logic [7:0] x, input bit force_pv);
        bit          pv;
        bit          rdy;
        bit          iss;
        bit          pp;
        bit          ps;
        logic [39:0] pd;
        checks++;
        if (count_o !== 4'(q.size())) $display("FAIL count cyc=%0d got %0d expected %0d", cyc, count_o, q.size());
        else passed++;
        checks++;
        if (m_axis_tvalid_o !== (q.size() != 0)) $display("FAIL tvalid cyc=%0d got %0b expected %0b", cyc, m_axis_tvalid_o, q.size() != 0);
        else passed++;
        if (q.size() != 0) begin
            checks++;
            if (m_axis_tdata_o !== q[0]) $display("FAIL tdata cyc=%0d got %0d expected %0d", cyc, m_axis_tdata_o, q[0]);
            else passed++;
        end
        checks++;
        if (issue_ready_o !== (reserved_m < 8)) $display("FAIL issue_ready cyc=%0d got %0b expected %0b", cyc, issue_ready_o, reserved_m < 8);
        else passed++;
        checks++;
        if (overflow_o !== ovf_m) $display("FAIL overflow cyc=%0d got %0b expected %0b", cyc, overflow_o, ovf_m);
        else passed++;
        checks++;
        if (issue_err_o !== err_m) $display("FAIL issue_err cyc=%0d got %0b expected %0b", cyc, issue_err_o, err_m);
        else passed++;
`ifdef POW5_BUF_TLAST_EN
        checks++;
        if (m_axis_tlast_o !== (q.size() != 0 && beats_m == 3)) $display("FAIL tlast cyc=%0d got %0b expected %0b", cyc, m_axis_tlast_o, q.size() != 0 && beats_m == 3);
        else passed++;
`endif
        pv = 0;
        pd = 40'({$urandom, $urandom});
        if (sched.size() != 0 && sched[0].due == cyc) begin
            pv = 1;
            pd = sched[0].d;
            void'(sched.pop_front());
        end
        if (force_pv) pv = 1;
        issue_valid_i   = iv;
        m_axis_tready_i = tr;
        pipe_valid_i    = pv;
        pipe_data_i     = pd;
        rdy = reserved_m < 8;
        iss = iv && rdy;
        pp  = tr && q.size() != 0;
        ps  = pv && (q.size() < 8 || pp);
        if (iv && !rdy) err_m = 1;
        if (pv && !ps) ovf_m = 1;
        if (pp) begin
            void'(q.pop_front());
            beats_m = (beats_m + 1) % 4;
        end
        if (ps) q.push_back(pd);
        reserved_m = reserved_m + int'(iss) - int'(pp);
        if (iss) sched.push_back('{cyc + 5, pow5(x)});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset taken at any point of the cycle; outputs must clear before any clock edge
    task automatic test_reset(input string tag);
        rst_n_i = 1'b0;
        issue_valid_i = 1'b0;
        m_axis_tready_i = 1'b0;
        pipe_valid_i = 1'b0;
        #2;
        checks++;
        if (count_o !== 4'd0) $display("FAIL %s_count got %0d expected 0", tag, count_o);
        else passed++;
        checks++;
        if (m_axis_tvalid_o !== 1'b0) $display("FAIL %s_tvalid got %0b expected 0", tag, m_axis_tvalid_o);
        else passed++;
        checks++;
        if (issue_ready_o !== 1'b1) $display("FAIL %s_ready got %0b expected 1", tag, issue_ready_o);
        else passed++;
        checks++;
        if (overflow_o !== 1'b0 || issue_err_o !== 1'b0) $display("FAIL %s_flags got %0b%0b expected 00", tag, overflow_o, issue_err_o);
        else passed++;
        q.delete();
        sched.delete();
        reserved_m = 0;
        ovf_m = 0;
        err_m = 0;
        beats_m = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        cyc++;
    endtask

    task automatic test_streaming();
        int          c0;
        int          seen_cyc[$];
        logic [39:0] got[$];
        c0 = cyc;
        step(1, 1, 8'd2, 0);
        step(1, 1, 8'd3, 0);
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid_o) begin
                got.push_back(m_axis_tdata_o);
                seen_cyc.push_back(cyc);
            end
            step(0, 1, 8'd0, 0);
        end
        checks++;
        if (got.size() != 2) $display("FAIL stream_beats got %0d expected 2", got.size());
        else begin
            passed++;
            checks++;
            if (got[0] !== 40'd32 || got[1] !== 40'd243) $display("FAIL stream_data got %0d,%0d expected 32,243", got[0], got[1]);
            else passed++;
            checks++;
            if (seen_cyc[0] != c0 + 6 || seen_cyc[1] != c0 + 7) $display("FAIL stream_latency got %0d,%0d expected %0d,%0d", seen_cyc[0] - c0, seen_cyc[1] - c0, 6, 7);
            else passed++;
        end
    endtask

    task automatic test_credit_stall();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (issue_ready_o !== (i < 8)) $display("FAIL stall_ready issue=%0d got %0b expected %0b", i, issue_ready_o, i < 8);
            else passed++;
            step(i < 8, 0, 8'($urandom), 0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 8'd0, 0);
        checks++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || issue_ready_o !== 1'b0) $display("FAIL stall_full got count=%0d ovf=%0b rdy=%0b expected count=8 ovf=0 rdy=0", count_o, overflow_o, issue_ready_o);
        else passed++;
    endtask

    task automatic test_issue_err();
        step(1, 0, 8'd7, 0);
        step(0, 0, 8'd0, 0);
        checks++;
        if (issue_err_o !== 1'b1 || issue_ready_o !== 1'b0 || count_o !== 4'd8) $display("FAIL issue_err got err=%0b rdy=%0b count=%0d expected err=1 rdy=0 count=8", issue_err_o, issue_ready_o, count_o);
        else passed++;
    endtask

    task automatic test_overflow();
        step(0, 0, 8'd0, 1);
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 4'd8) $display("FAIL overflow got ovf=%0b count=%0d expected ovf=1 count=8", overflow_o, count_o);
        else passed++;
        step(0, 0, 8'd0, 0);
    endtask

    task automatic test_full_push_pop();
        step(0, 1, 8'd0, 1);
        checks++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0) $display("FAIL full_pushpop got count=%0d ovf=%0b expected count=8 ovf=0", count_o, overflow_o);
        else passed++;
        for (int i = 0; i < 3; i++) step(0, 1, 8'd0, 0);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'd0, 0);
        checks++;
        if (count_o !== 4'd3) $display("FAIL midreset_queued got %0d expected 3", count_o);
        else passed++;
        #3;
        test_reset("midreset");
        for (int i = 0; i < 8; i++) step(0, 1, 8'd0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 8'($urandom), 0);
        for (int i = 0; i < 20; i++) step(0, 1, 8'd0, 0);
    endtask

`ifdef POW5_BUF_TLAST_EN
    task automatic test_tlast();
        int       pops = 0;
        bit [7:0] lasts = '0;
        bit       tr;
        for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 200 && pops < 8; i++) begin
            tr = 1'($urandom_range(0, 1));
            if (tr && m_axis_tvalid_o) begin
                lasts[pops] = m_axis_tlast_o;
                pops++;
            end
            step(0, tr, 8'd0, 0);
        end
        checks++;
        if (pops != 8 || lasts !== 8'b1000_1000) $display("FAIL tlast_packet got pops=%0d mask=%b expected pops=8 mask=10001000", pops, lasts);
        else passed++;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset("reset");
        test_streaming();
        test_credit_stall();
        test_issue_err();
        test_overflow();
        test_reset("reset2");
        test_credit_stall();
        test_full_push_pop();
        test_reset("reset3");
        test_reset_midstream();
        test_random();
`ifdef POW5_BUF_TLAST_EN
        test_reset("reset4");
        test_tlast();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
